// File: rtl/mod_pkg.sv
// Shared types and defaults for the multi-channel modulation envelope generator.
package mod_pkg;

   localparam int unsigned DEF_CNT_W  = 16;
   localparam int unsigned DEF_NUM_CH = 4;

   typedef struct packed {
      logic [DEF_CNT_W-1:0] period;
      logic [DEF_CNT_W-1:0] high;
      logic [DEF_CNT_W-1:0] phase;
   } mod_cfg_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } chan_state_e;

endpackage

// File: rtl/mod_channel.sv
// One modulation channel: shadow/active config, tick counter and registered envelope output.
module mod_channel
   import mod_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             resync,
   input  logic             enable,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_period,
   input  logic [CNT_W-1:0] wr_high,
   input  logic [CNT_W-1:0] wr_phase,
   output logic             mod_out,
   output logic             wrap_pulse
);

   localparam int unsigned EXT_W = CNT_W + 1;

   typedef struct packed {
      logic [CNT_W-1:0] period;
      logic [CNT_W-1:0] high;
      logic [CNT_W-1:0] phase;
   } cfg_t;

   // A phase outside the period restarts the channel at zero.
   function automatic logic [CNT_W-1:0] start_cnt(input cfg_t c);
      return (c.phase >= c.period) ? '0 : c.phase;
   endfunction

   chan_state_e      state_q, state_d;
   cfg_t             shadow_q, shadow_d;
   cfg_t             active_q, active_d;
   cfg_t             wr_cfg;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [EXT_W-1:0] cnt_inc;
   logic             tick_wrap;
   logic             mod_out_d;
   logic             wrap_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shadow_q   <= '0;
         active_q   <= '0;
         cnt_q      <= '0;
         mod_out    <= 1'b1;
         wrap_pulse <= 1'b0;
      end else begin
         state_q    <= state_d;
         shadow_q   <= shadow_d;
         active_q   <= active_d;
         cnt_q      <= cnt_d;
         mod_out    <= mod_out_d;
         wrap_pulse <= wrap_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      shadow_d      = shadow_q;
      active_d      = active_q;
      cnt_d         = cnt_q;
      mod_out_d     = 1'b1;
      wrap_d        = 1'b0;
      wr_cfg.period = wr_period;
      wr_cfg.high   = wr_high;
      wr_cfg.phase  = wr_phase;
      // Extra bit keeps the wrap compare exact at an all-ones period.
      cnt_inc       = {1'b0, cnt_q} + EXT_W'(1);
      tick_wrap     = cnt_inc >= {1'b0, active_q.period};

      if (wr) shadow_d = wr_cfg;

      case (state_q)
         IDLE: if (enable)  state_d = RUN;
         RUN:  if (!enable) state_d = IDLE;
      endcase

      if (state_d == IDLE) begin
         // Disabled: track the shadow (including a same-cycle write) and park at phase.
         active_d = shadow_d;
         cnt_d    = start_cnt(shadow_d);
      end else begin
         if (resync) begin
            cnt_d = start_cnt(active_q);
         end else if (tick) begin
            if (tick_wrap) begin
               cnt_d    = '0;
               active_d = shadow_q;
               wrap_d   = 1'b1;
            end else begin
               cnt_d = cnt_inc[CNT_W-1:0];
            end
         end
         mod_out_d = cnt_d < active_d.high;
      end
   end

endmodule

// File: rtl/mod_gen.sv
// Multi-channel modulation generator: sync edge detect, config decode and channel array.
module mod_gen
   import mod_pkg::*;
#(
   parameter int unsigned NUM_CH = DEF_NUM_CH,
   parameter int unsigned CNT_W  = DEF_CNT_W,
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sync,
   input  logic              resync,
   input  logic [NUM_CH-1:0] mod_enable,
   input  logic              cfg_wr,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_period,
   input  logic [CNT_W-1:0]  cfg_high,
   input  logic [CNT_W-1:0]  cfg_phase,
   output logic [NUM_CH-1:0] mod_out,
   output logic [NUM_CH-1:0] wrap_pulse
);

   logic sync_q;
   logic tick;

   // Resets high so a sync already asserted at reset release is not a tick.
   always_ff @(posedge clk) begin
      if (rst) sync_q <= 1'b1;
      else     sync_q <= sync;
   end

   assign tick = sync & ~sync_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic ch_wr;

      assign ch_wr = cfg_wr && (cfg_ch == CH_W'(i));

      mod_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .tick       (tick),
         .resync     (resync),
         .enable     (mod_enable[i]),
         .wr         (ch_wr),
         .wr_period  (cfg_period),
         .wr_high    (cfg_high),
         .wr_phase   (cfg_phase),
         .mod_out    (mod_out[i]),
         .wrap_pulse (wrap_pulse[i])
      );
   end

endmodule

// File: tb/tb_mod_gen.sv
// Self-checking bench for mod_gen: expected outputs queued per tick and compared after it.
module tb_mod_gen;
   import mod_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        sync;
   logic        resync;
   logic [3:0]  mod_enable;
   logic        cfg_wr;
   logic [1:0]  cfg_ch;
   logic [15:0] cfg_period;
   logic [15:0] cfg_high;
   logic [15:0] cfg_phase;
   logic [3:0]  mod_out;
   logic [3:0]  wrap_pulse;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [3:0] out;
      logic [3:0] wrap;
   } exp_t;

   exp_t sb_q[$];

   mod_gen #(.NUM_CH(4), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .sync       (sync),
      .resync     (resync),
      .mod_enable (mod_enable),
      .cfg_wr     (cfg_wr),
      .cfg_ch     (cfg_ch),
      .cfg_period (cfg_period),
      .cfg_high   (cfg_high),
      .cfg_phase  (cfg_phase),
      .mod_out    (mod_out),
      .wrap_pulse (wrap_pulse)
   );

   always #5 clk = ~clk;

   function automatic mod_cfg_t mk(int p, int h, int ph);
      mod_cfg_t c;
      c.period = 16'(p);
      c.high   = 16'(h);
      c.phase  = 16'(ph);
      return c;
   endfunction

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_cfg(logic [1:0] ch, mod_cfg_t c);
      cfg_ch     = ch;
      cfg_period = c.period;
      cfg_high   = c.high;
      cfg_phase  = c.phase;
   endtask

   task automatic write_cfg(logic [1:0] ch, mod_cfg_t c);
      @(negedge clk);
      set_cfg(ch, c);
      cfg_wr = 1'b1;
      @(negedge clk);
      cfg_wr = 1'b0;
   endtask

   // One sync pulse; returns at the negedge right after the tick edge.
   task automatic tick(logic with_wr, logic with_resync);
      @(negedge clk);
      sync   = 1'b1;
      cfg_wr = with_wr;
      resync = with_resync;
      @(negedge clk);
      sync   = 1'b0;
      cfg_wr = 1'b0;
      resync = 1'b0;
   endtask

   task automatic push(logic [3:0] o, logic [3:0] w);
      exp_t e;
      e.out  = o;
      e.wrap = w;
      sb_q.push_back(e);
   endtask

   task automatic test_reset;
      exp_t e;
      rst = 1'b1; sync = 1'b1; resync = 1'b0; cfg_wr = 1'b0;
      mod_enable = 4'hF;
      set_cfg(2'd0, mk(0, 0, 0));
      cyc(3);
      total++;
      if (mod_out !== 4'hF) begin bad++; $display("FAIL reset_out got=%b exp=%b", mod_out, 4'hF); end
      total++;
      if (wrap_pulse !== 4'h0) begin bad++; $display("FAIL reset_wrap got=%b exp=%b", wrap_pulse, 4'h0); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (wrap_pulse !== 4'h0) begin bad++; $display("FAIL sync_hold_wrap i=%0d got=%b exp=%b", i, wrap_pulse, 4'h0); end
      end
      total++;
      if (mod_out !== 4'h0) begin bad++; $display("FAIL zero_cfg_out got=%b exp=%b", mod_out, 4'h0); end
      @(negedge clk);
      sync = 1'b0;
      push(4'h0, 4'hF);
      tick(1'b0, 1'b0);
      e = sb_q.pop_front();
      total++;
      if (mod_out !== e.out) begin bad++; $display("FAIL period0_out got=%b exp=%b", mod_out, e.out); end
      total++;
      if (wrap_pulse !== e.wrap) begin bad++; $display("FAIL period0_wrap got=%b exp=%b", wrap_pulse, e.wrap); end
      mod_enable = 4'h0;
      cyc(2);
   endtask

   task automatic test_legacy;
      exp_t e;
      int c;
      write_cfg(2'd0, mk(8, 4, 0));
      mod_enable = 4'b0001;
      cyc(2);
      total++;
      if (mod_out !== 4'hF) begin bad++; $display("FAIL legacy_start got=%b exp=%b", mod_out, 4'hF); end
      for (int t = 1; t <= 20; t++) begin
         c = t % 8;
         push({3'b111, c < 4}, {3'b000, c == 0});
         tick(1'b0, 1'b0);
         e = sb_q.pop_front();
         total++;
         if (mod_out !== e.out) begin bad++; $display("FAIL legacy_out t=%0d got=%b exp=%b", t, mod_out, e.out); end
         total++;
         if (wrap_pulse !== e.wrap) begin bad++; $display("FAIL legacy_wrap t=%0d got=%b exp=%b", t, wrap_pulse, e.wrap); end
      end
      mod_enable = 4'b0000;
      @(negedge clk);
      total++;
      if (mod_out !== 4'hF) begin bad++; $display("FAIL disable_out got=%b exp=%b", mod_out, 4'hF); end
   endtask

   task automatic test_edges;
      exp_t e;
      write_cfg(2'd1, mk(8, 0, 0));
      write_cfg(2'd2, mk(5, 10, 0));
      write_cfg(2'd3, mk(1, 0, 0));
      mod_enable = 4'b1110;
      cyc(2);
      total++;
      if (mod_out !== 4'b0101) begin bad++; $display("FAIL edges_start got=%b exp=%b", mod_out, 4'b0101); end
      for (int t = 1; t <= 6; t++) begin
         push(4'b0101, {1'b1, (t % 5) == 0, 2'b00});
         tick(1'b0, 1'b0);
         e = sb_q.pop_front();
         total++;
         if (mod_out !== e.out) begin bad++; $display("FAIL edges_out t=%0d got=%b exp=%b", t, mod_out, e.out); end
         total++;
         if (wrap_pulse !== e.wrap) begin bad++; $display("FAIL edges_wrap t=%0d got=%b exp=%b", t, wrap_pulse, e.wrap); end
      end
      @(negedge clk);
      total++;
      if (wrap_pulse !== 4'h0) begin bad++; $display("FAIL wrap_one_cycle got=%b exp=%b", wrap_pulse, 4'h0); end
      mod_enable = 4'h0;
      cyc(2);
   endtask

   task automatic test_glitch_free;
      exp_t e;
      int c;
      int h;
      logic wr;
      write_cfg(2'd0, mk(8, 4, 0));
      mod_enable = 4'b0001;
      cyc(1);
      for (int t = 1; t <= 30; t++) begin
         if (t <= 8) begin
            c = t % 8; h = 4;
         end else if (t <= 24) begin
            c = (t - 8) % 4; h = 2;
         end else begin
            c = (t - 24) % 6; h = 3;
         end
         wr = 1'b0;
         if (t == 3) begin set_cfg(2'd0, mk(4, 2, 0)); wr = 1'b1; end
         if (t == 20) begin set_cfg(2'd0, mk(6, 3, 0)); wr = 1'b1; end
         push({3'b111, c < h}, {3'b000, c == 0});
         tick(wr, 1'b0);
         e = sb_q.pop_front();
         total++;
         if (mod_out !== e.out) begin bad++; $display("FAIL update_out t=%0d got=%b exp=%b", t, mod_out, e.out); end
         total++;
         if (wrap_pulse !== e.wrap) begin bad++; $display("FAIL update_wrap t=%0d got=%b exp=%b", t, wrap_pulse, e.wrap); end
      end
      mod_enable = 4'h0;
      cyc(2);
   endtask

   task automatic test_phase_resync;
      exp_t e;
      int c0;
      int c1;
      write_cfg(2'd0, mk(8, 4, 0));
      write_cfg(2'd1, mk(8, 4, 4));
      mod_enable = 4'b0011;
      cyc(1);
      total++;
      if (mod_out !== 4'b1101) begin bad++; $display("FAIL phase_start got=%b exp=%b", mod_out, 4'b1101); end
      for (int t = 1; t <= 3; t++) begin
         c0 = t; c1 = (t + 4) % 8;
         push({2'b11, c1 < 4, c0 < 4}, {2'b00, c1 == 0, c0 == 0});
         tick(1'b0, 1'b0);
         e = sb_q.pop_front();
         total++;
         if (mod_out !== e.out) begin bad++; $display("FAIL phase_out t=%0d got=%b exp=%b", t, mod_out, e.out); end
         total++;
         if (wrap_pulse !== e.wrap) begin bad++; $display("FAIL phase_wrap t=%0d got=%b exp=%b", t, wrap_pulse, e.wrap); end
      end
      push(4'b1101, 4'b0000);
      tick(1'b0, 1'b1);
      e = sb_q.pop_front();
      total++;
      if (mod_out !== e.out) begin bad++; $display("FAIL resync_out got=%b exp=%b", mod_out, e.out); end
      total++;
      if (wrap_pulse !== e.wrap) begin bad++; $display("FAIL resync_wrap got=%b exp=%b", wrap_pulse, e.wrap); end
      for (int k = 1; k <= 4; k++) begin
         c0 = k; c1 = (k + 4) % 8;
         push({2'b11, c1 < 4, c0 < 4}, {2'b00, c1 == 0, c0 == 0});
         tick(1'b0, 1'b0);
         e = sb_q.pop_front();
         total++;
         if (mod_out !== e.out) begin bad++; $display("FAIL post_resync_out k=%0d got=%b exp=%b", k, mod_out, e.out); end
         total++;
         if (wrap_pulse !== e.wrap) begin bad++; $display("FAIL post_resync_wrap k=%0d got=%b exp=%b", k, wrap_pulse, e.wrap); end
      end
   endtask

   task automatic test_midrun_reset;
      exp_t e;
      for (int k = 0; k < 3; k++) tick(1'b0, 1'b0);
      // ch0 now sits at period-1, so this tick would wrap without the reset.
      @(negedge clk);
      sync = 1'b1;
      rst  = 1'b1;
      @(negedge clk);
      total++;
      if (mod_out !== 4'hF) begin bad++; $display("FAIL midrun_reset_out got=%b exp=%b", mod_out, 4'hF); end
      total++;
      if (wrap_pulse !== 4'h0) begin bad++; $display("FAIL midrun_reset_wrap got=%b exp=%b", wrap_pulse, 4'h0); end
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if (wrap_pulse !== 4'h0) begin bad++; $display("FAIL release_wrap i=%0d got=%b exp=%b", i, wrap_pulse, 4'h0); end
      end
      total++;
      if (mod_out !== 4'b1100) begin bad++; $display("FAIL release_out got=%b exp=%b", mod_out, 4'b1100); end
      sync = 1'b0;
      push(4'b1100, 4'b0011);
      tick(1'b0, 1'b0);
      e = sb_q.pop_front();
      total++;
      if (mod_out !== e.out) begin bad++; $display("FAIL post_reset_out got=%b exp=%b", mod_out, e.out); end
      total++;
      if (wrap_pulse !== e.wrap) begin bad++; $display("FAIL post_reset_wrap got=%b exp=%b", wrap_pulse, e.wrap); end
   endtask

   initial begin
      test_reset();
      test_legacy();
      test_edges();
      test_glitch_free();
      test_phase_resync();
      test_midrun_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mod_gen.md
# mod_gen

Multi-channel, parametrised successor to the single-channel square-wave modulator. It is clocked from the system clock and advances once per rising edge of the transducer `sync` strobe. Each channel independently produces a modulation envelope with programmable period, high time and start phase. Configuration is double-buffered so updates are glitch-free, and `mod_out` gates the per-channel drive enables downstream.

## Interface
Parameters:
- `NUM_CH`, 4: number of independent modulation channels.
- `CNT_W`, 16: width of the period, high-time, phase and counter fields.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `sync` in 1: sync strobe; its rising edge is the modulation tick.
- `resync` in 1: one-cycle pulse; realigns all enabled channels to their phase.
- `mod_enable` in NUM_CH: per-channel enable.
- `cfg_wr` in 1: configuration write strobe.
- `cfg_ch` in $clog2(NUM_CH): target channel.
- `cfg_period` in CNT_W: period in ticks.
- `cfg_high` in CNT_W: ticks high per period.
- `cfg_phase` in CNT_W: counter start value.
- `mod_out` out NUM_CH: registered modulation output; 1 when disabled.
- `wrap_pulse` out NUM_CH: one-cycle pulse when the channel counter wraps to 0.

## Operation
- Tick detection: `tick = sync & ~sync_q`, where `sync_q` is a registered copy of `sync`. `sync_q` resets to 1, so a `sync` held high through reset release does not tick.
- Each channel has shadow {period, high, phase} and active {period, high, phase}, plus counter `cnt`.
- `cfg_wr` writes the three fields into the shadow of `cfg_ch`. Out-of-range `cfg_ch` is ignored.
- Shadow-to-active copy happens:
  - on any cycle the channel is disabled, continuously; or
  - on the cycle its counter wraps.
- If `cfg_wr` and a wrap coincide on the same channel, the active set loads the pre-write shadow and the new values apply at the next wrap.
- Channel states:
  - IDLE (`mod_enable`=0): `cnt` is held at active phase and `mod_out`=1.
  - RUN: on each tick, `cnt <= (cnt+1 >= period) ? 0 : cnt+1`. Comparison is done at CNT_W+1 bits, so there is no overflow at all-ones.
- IDLE→RUN happens on `mod_enable` 0→1. The first counted value is phase+1 on the first tick.
- Phase ≥ period is treated as phase 0.
- In RUN, `mod_out = (cnt < high)`, evaluated on the updated `cnt`.
  - high=0 gives constant 0.
  - high ≥ period gives constant 1.
  - period ≤ 1 holds `cnt`=0.
- Compatibility with the legacy block: period=2·H, high=H, phase=0 reproduces a square wave toggling every H ticks. Polarity starts high.
- `resync` loads `cnt <= phase` in all RUN channels and raises no `wrap_pulse`. `resync` takes priority over a tick in the same cycle.
- `wrap_pulse[i]` is asserted for the cycle after a tick that moves `cnt` from period-1 to 0. A wrap caused by period ≤ 1 pulses on every tick.

## Timing
- Reset values:
  - `mod_out` = all 1s.
  - `wrap_pulse` = 0.
  - `cnt`, shadow and active = 0.
  - `sync_q` = 1.
- Latency: if `sync` rises in cycle T (tick asserted in T), then `cnt`, `mod_out` and `wrap_pulse` change in cycle T+1.
- Enable/disable latency: `mod_enable` falling in T gives `mod_out`=1 in T+1.
- Config latency: a `cfg_wr` in T while disabled is active in T+1.
- Reset mid-period: everything returns to reset values in the next cycle, and no `wrap_pulse` is issued.
- Ticks closer than 2 cycles apart are impossible, since `sync` must fall between them. No minimum high width is required on `sync` beyond 1 cycle.

## Structure
- Package `mod_pkg`:
  - `CNT_W` default.
  - `mod_cfg_t` struct {period, high, phase}.
  - Channel state enum {IDLE, RUN}.
- Sub-module `mod_channel`: holds one channel's shadow/active registers, counter and output. It is instantiated NUM_CH times by a generate loop.
- The top level owns tick detection, `resync` fan-out and `cfg_wr` decode.

## Test plan
- Legacy square wave: period=8, high=4, phase=0, enable ch0, 20 sync pulses → `mod_out[0]` is low after ticks 4, 12, high after ticks 8, 16; `wrap_pulse` after ticks 8, 16.
- Duty and edge cases, ch1 high=0 → constant 0; ch2 high=10, period=5 → constant 1; ch3 period=1 → `wrap_pulse` every tick; disabled channel → 1.
- Glitch-free update: while running period=8, write period=4 at tick 3 → old period finishes at tick 8, then wraps every 4 ticks. Write coincident with a wrap applies one period later.
- Phase and resync: ch0 phase=0, ch1 phase=4, period=8, high=4 → outputs are 180° apart. `resync` mid-run with a simultaneous tick → both counters equal their phase, no `wrap_pulse`.
- Reset: `sync` held high across `rst` release → no tick. Reset asserted mid-run → `mod_out` all 1s next cycle, counters 0.
